dsa_pixel_fetch: RTL and testbench
==================================

Name: dsa_pixel_fetch

Overview:
Fetch stage for the sequential bilinear DSA. It sits between the control FSM and the interpolation datapath. On each fetch_req it maps the output coordinate (dst_x, dst_y) to a fixed-point source coordinate and clamps the neighbour indices. It then reads the four neighbour pixels from source-image memory, one outstanding read at a time, and presents the pixels plus fractional weights to the datapath with a one-cycle fetch_done pulse.

Parameters:
ADDR_W, 18, source memory word-address width (512x512 = 2^18).
PIX_W, 8, pixel width.
FRAC_W, 8, fractional bits of the scale factor and of frac_x/frac_y.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
fetch_req  in  1  single-cycle request from control FSM; sampled only in ST_IDLE
dst_x  in  16  output-image x coordinate
dst_y  in  16  output-image y coordinate
img_width_in  in  16  source width W
img_height_in  in  16  source height H
scale_x  in  16  Q8.8 step, in_width/out_width
scale_y  in  16  Q8.8 step, in_height/out_height
base_addr  in  ADDR_W  source image base word address
mem_rd  out  1  read strobe, one cycle per read
mem_addr  out  ADDR_W  read address, valid while mem_rd=1
mem_rdata  in  PIX_W  read data
mem_rvalid  in  1  read data valid, variable latency
p00, p01, p10, p11  out  PIX_W each  neighbours (row y0/y1, column x0/x1)
frac_x, frac_y  out  FRAC_W each  interpolation weights
fetch_done  out  1  one-cycle pulse; outputs valid from this cycle onward
busy  out  1  high in every state except ST_IDLE

Behaviour:
- Reset: all outputs 0; state ST_IDLE; internal registers 0.
- States: ST_IDLE, ST_CALC, ST_ROW, ST_ISSUE, ST_WAIT, ST_DONE.
- ST_IDLE: if fetch_req=1, latch dst_x, dst_y and all configuration inputs, then go to ST_CALC. fetch_req in any other state is ignored (not queued).
- ST_CALC: compute src_x = dst_x*scale_x and src_y = dst_y*scale_y as 32-bit Q24.8 values.
  - int = src[23:8] (bits above 23 discarded); frac = src[7:0].
  - Wm1 = (W==0) ? 0 : W-1. Hm1 is formed the same way from H.
  - If int_x > Wm1: x0 = x1 = Wm1 and frac_x = 0.
  - Else: x0 = int_x, x1 = min(x0+1, Wm1), frac_x = frac.
  - Y is handled identically with Hm1. Go to ST_ROW.
- ST_ROW: register row0 = base_addr + y0*W and row1 = base_addr + y1*W, truncated to ADDR_W. Clear read index idx = 0. Go to ST_ISSUE.
- ST_ISSUE: mem_rd = 1 for exactly one cycle. Go to ST_WAIT.
  - mem_addr by idx: 0 = row0+x0, 1 = row0+x1, 2 = row1+x0, 3 = row1+x1.
  - mem_rvalid in this cycle is ignored.
- ST_WAIT: wait for mem_rvalid with no timeout. On rvalid, store mem_rdata in shadow[idx].
  - If idx==3, go to ST_DONE.
  - Else idx++ and go to ST_ISSUE.
- ST_DONE: copy the shadows to p00..p11 and frac_x/frac_y to the outputs; fetch_done = 1. Go to ST_IDLE.
- Output registers change only in ST_DONE. They hold their values until the next ST_DONE.
- Latency with 1-cycle memory: fetch_req sampled in cycle T gives fetch_done in cycle T+11. Each extra memory wait cycle adds one cycle.
- Coincident edge pixels (x1==x0 or y1==y0) are still read as four separate reads; no read elision.
- rst mid-operation (any state, including ST_WAIT): return to ST_IDLE immediately with outputs cleared. A late mem_rvalid arriving in ST_IDLE is ignored.
- Multipliers are 16x16 -> 32. Address arithmetic is performed modulo 2^ADDR_W.

Decomposition:
- Shared package dsa_pkg:
  - fetch state enum (fetch_state_t)
  - FRAC_W, PIX_W, ADDR_W defaults
  - neighbour index constants NB_00..NB_11
- One sub-module, dsa_coord_map: combinational scale/clamp of one axis.
  - Inputs: dst, scale, dim.
  - Outputs: i0, i1, frac.
  - Instantiated twice (x and y) and registered in ST_CALC.

Test Plan:
- Upscale interior point. Setup: W=H=4, scale_x=scale_y=0x0080, base 0, 1-cycle memory, dst (3,5).
  - Required: reads at 9, 10, 13, 14 in that order.
  - Required: frac_x = frac_y = 0x80; p00..p11 match memory contents; fetch_done exactly 11 cycles after fetch_req.
- Edge clamp. Same setup, dst (7,7).
  - Required: x0 = x1 = 3, y0 = y1 = 3; four reads all at address 15; frac = 0x80 on both axes.
- Out-of-range clamp. scale_x=0x0100, W=4, dst_x=5.
  - Required: x0 = x1 = 3 and frac_x = 0.
- Identity with base offset. scale 0x0100, base_addr=0x100, W=4, dst (2,1).
  - Required: addresses 0x106, 0x107, 0x10A, 0x10B; frac_x = frac_y = 0.
- Variable latency and ignored request. Random 1-5 cycle rvalid delay, plus a second fetch_req pulsed while busy.
  - Required: exactly 4 mem_rd pulses and one fetch_done.
  - Required: outputs unchanged before fetch_done; the second request is dropped.
- Reset mid-read. Assert rst in ST_WAIT after the second read.
  - Required: all outputs 0, busy = 0, no further mem_rd.
  - Required: a late rvalid is ignored, and the next fetch_req completes normally.

Source files
------------

// File: rtl/dsa_pkg.sv
// Shared types and defaults for the bilinear DSA fetch path.
package dsa_pkg;

    localparam int unsigned DSA_ADDR_W = 18;
    localparam int unsigned DSA_PIX_W  = 8;
    localparam int unsigned DSA_FRAC_W = 8;
    localparam int unsigned DIM_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_ROW,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } fetch_state_t;

    // Read order; bit 1 selects the row (y0/y1), bit 0 the column (x0/x1).
    localparam logic [1:0] NB_00 = 2'd0;
    localparam logic [1:0] NB_01 = 2'd1;
    localparam logic [1:0] NB_10 = 2'd2;
    localparam logic [1:0] NB_11 = 2'd3;

endpackage

// File: rtl/dsa_coord_map.sv
// One axis of output->source mapping: fixed-point scale, then clamp of both neighbours.
module dsa_coord_map
    import dsa_pkg::*;
#(
    parameter int unsigned FRAC_W = DSA_FRAC_W
) (
    input  logic [DIM_W-1:0]  dst,
    input  logic [DIM_W-1:0]  scale,
    input  logic [DIM_W-1:0]  dim,
    output logic [DIM_W-1:0]  i0,
    output logic [DIM_W-1:0]  i1,
    output logic [FRAC_W-1:0] frac
);

    localparam int unsigned MW = 2 * DIM_W;
    localparam int unsigned PW = DIM_W + FRAC_W;

    logic [PW-1:0]    prod;
    logic [DIM_W-1:0] int_v;
    logic [DIM_W-1:0] dm1;

    always_comb begin
        prod  = PW'(MW'(dst) * MW'(scale));
        int_v = prod[PW-1:FRAC_W];
        dm1   = (dim == '0) ? '0 : dim - DIM_W'(1);
        i0    = dm1;
        i1    = dm1;
        frac  = '0;
        if (int_v <= dm1) begin
            i0   = int_v;
            i1   = (int_v < dm1) ? int_v + DIM_W'(1) : dm1;
            frac = prod[FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/dsa_pixel_fetch.sv
// Fetch stage: maps an output coordinate to four clamped source neighbours and reads them serially.
module dsa_pixel_fetch
    import dsa_pkg::*;
#(
    parameter int unsigned ADDR_W = DSA_ADDR_W,
    parameter int unsigned PIX_W  = DSA_PIX_W,
    parameter int unsigned FRAC_W = DSA_FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [15:0]       dst_x,
    input  logic [15:0]       dst_y,
    input  logic [15:0]       img_width_in,
    input  logic [15:0]       img_height_in,
    input  logic [15:0]       scale_x,
    input  logic [15:0]       scale_y,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    input  logic              mem_rvalid,
    output logic [PIX_W-1:0]  p00,
    output logic [PIX_W-1:0]  p01,
    output logic [PIX_W-1:0]  p10,
    output logic [PIX_W-1:0]  p11,
    output logic [FRAC_W-1:0] frac_x,
    output logic [FRAC_W-1:0] frac_y,
    output logic              fetch_done,
    output logic              busy
);

    localparam int unsigned MW = 2 * DIM_W;

    fetch_state_t state_q, state_d;

    logic [DIM_W-1:0]  dx_q, dx_d, dy_q, dy_d, w_q, w_d, h_q, h_d;
    logic [DIM_W-1:0]  sx_q, sx_d, sy_q, sy_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DIM_W-1:0]  x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [FRAC_W-1:0] fx_q, fx_d, fy_q, fy_d;
    logic [ADDR_W-1:0] row0_q, row0_d, row1_q, row1_d;
    logic [1:0]        idx_q, idx_d;
    logic [PIX_W-1:0]  shadow_q [4];
    logic [PIX_W-1:0]  shadow_d [4];

    logic              mem_rd_q, mem_rd_d, done_q, done_d, busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d, row_sel;
    logic [PIX_W-1:0]  p00_q, p00_d, p01_q, p01_d, p10_q, p10_d, p11_q, p11_d;
    logic [FRAC_W-1:0] ofx_q, ofx_d, ofy_q, ofy_d;

    logic [DIM_W-1:0]  cx0, cx1, cy0, cy1;
    logic [FRAC_W-1:0] cfx, cfy;

    dsa_coord_map #(.FRAC_W(FRAC_W)) u_map_x (
        .dst(dx_q), .scale(sx_q), .dim(w_q), .i0(cx0), .i1(cx1), .frac(cfx)
    );

    dsa_coord_map #(.FRAC_W(FRAC_W)) u_map_y (
        .dst(dy_q), .scale(sy_q), .dim(h_q), .i0(cy0), .i1(cy1), .frac(cfy)
    );

    // Next-state and next-output logic; registered outputs are loaded from the _d view.
    always_comb begin
        state_d  = state_q;
        dx_d     = dx_q;   dy_d   = dy_q;   w_d    = w_q;    h_d    = h_q;
        sx_d     = sx_q;   sy_d   = sy_q;   base_d = base_q;
        x0_d     = x0_q;   x1_d   = x1_q;   y0_d   = y0_q;   y1_d   = y1_q;
        fx_d     = fx_q;   fy_d   = fy_q;
        row0_d   = row0_q; row1_d = row1_q; idx_d  = idx_q;
        shadow_d = shadow_q;
        mem_rd_d = 1'b0;
        done_d   = 1'b0;
        addr_d   = addr_q;
        p00_d    = p00_q;  p01_d  = p01_q;  p10_d  = p10_q;  p11_d  = p11_q;
        ofx_d    = ofx_q;  ofy_d  = ofy_q;
        row_sel  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (fetch_req) begin
                    dx_d    = dst_x;          dy_d = dst_y;
                    w_d     = img_width_in;   h_d  = img_height_in;
                    sx_d    = scale_x;        sy_d = scale_y;
                    base_d  = base_addr;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                x0_d    = cx0; x1_d = cx1; fx_d = cfx;
                y0_d    = cy0; y1_d = cy1; fy_d = cfy;
                state_d = ST_ROW;
            end
            ST_ROW: begin
                row0_d  = base_q + ADDR_W'(MW'(y0_q) * MW'(w_q));
                row1_d  = base_q + ADDR_W'(MW'(y1_q) * MW'(w_q));
                idx_d   = NB_00;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_rvalid) begin
                    shadow_d[idx_q] = mem_rdata;
                    if (idx_q == NB_11) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = 2'(idx_q + 2'd1);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ISSUE) begin
            mem_rd_d = 1'b1;
            row_sel  = idx_d[1] ? row1_d : row0_d;
            addr_d   = row_sel + ADDR_W'(idx_d[0] ? x1_q : x0_q);
        end

        if (state_d == ST_DONE) begin
            p00_d  = shadow_d[NB_00];
            p01_d  = shadow_d[NB_01];
            p10_d  = shadow_d[NB_10];
            p11_d  = shadow_d[NB_11];
            ofx_d  = fx_q;
            ofy_d  = fy_q;
            done_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dx_q     <= '0; dy_q <= '0; w_q <= '0; h_q <= '0;
            sx_q     <= '0; sy_q <= '0; base_q <= '0;
            x0_q     <= '0; x1_q <= '0; y0_q <= '0; y1_q <= '0;
            fx_q     <= '0; fy_q <= '0;
            row0_q   <= '0; row1_q <= '0; idx_q <= '0;
            for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
            mem_rd_q <= 1'b0; done_q <= 1'b0; busy_q <= 1'b0;
            addr_q   <= '0;
            p00_q    <= '0; p01_q <= '0; p10_q <= '0; p11_q <= '0;
            ofx_q    <= '0; ofy_q <= '0;
        end else begin
            state_q  <= state_d;
            dx_q     <= dx_d; dy_q <= dy_d; w_q <= w_d; h_q <= h_d;
            sx_q     <= sx_d; sy_q <= sy_d; base_q <= base_d;
            x0_q     <= x0_d; x1_q <= x1_d; y0_q <= y0_d; y1_q <= y1_d;
            fx_q     <= fx_d; fy_q <= fy_d;
            row0_q   <= row0_d; row1_q <= row1_d; idx_q <= idx_d;
            for (int i = 0; i < 4; i++) shadow_q[i] <= shadow_d[i];
            mem_rd_q <= mem_rd_d; done_q <= done_d; busy_q <= busy_d;
            addr_q   <= addr_d;
            p00_q    <= p00_d; p01_q <= p01_d; p10_q <= p10_d; p11_q <= p11_d;
            ofx_q    <= ofx_d; ofy_q <= ofy_d;
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = addr_q;
    assign p00        = p00_q;
    assign p01        = p01_q;
    assign p10        = p10_q;
    assign p11        = p11_q;
    assign frac_x     = ofx_q;
    assign frac_y     = ofy_q;
    assign fetch_done = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dsa_pixel_fetch.sv
// Scoreboard bench for dsa_pixel_fetch: expected reads/results queued at request time, checked by a monitor.
module tb_dsa_pixel_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [15:0] dst_x, dst_y, img_width_in, img_height_in, scale_x, scale_y;
    logic [17:0] base_addr;
    logic        mem_rd;
    logic [17:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic [7:0]  p00, p01, p10, p11, frac_x, frac_y;
    logic        fetch_done, busy;

    dsa_pixel_fetch dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req),
        .dst_x(dst_x), .dst_y(dst_y),
        .img_width_in(img_width_in), .img_height_in(img_height_in),
        .scale_x(scale_x), .scale_y(scale_y), .base_addr(base_addr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .p00(p00), .p01(p01), .p10(p10), .p11(p11),
        .frac_x(frac_x), .frac_y(frac_y), .fetch_done(fetch_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] p00, p01, p10, p11, fx, fy;
        int         lat;
    } exp_t;

    logic [17:0] exp_addr_q [$];
    exp_t        exp_res_q  [$];

    int total = 0, bad = 0;
    int cyc = 0, req_cyc = 0;
    int rd_count = 0, done_count = 0;
    int extra_lat = 0;
    bit rand_lat = 1'b0, chk_hold = 1'b0;
    logic [7:0] h00 = '0, h01 = '0, h10 = '0, h11 = '0, hfx = '0, hfy = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Source image content: a fixed scramble of the word address.
    function automatic logic [7:0] pix(input logic [17:0] a);
        return a[7:0] ^ 8'hA5 ^ {a[11:8], a[15:12]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: one response per mem_rd after 1 + extra cycles.
    initial begin
        logic [17:0] a;
        int d;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (mem_rd) begin
                a = mem_addr;
                d = rand_lat ? int'($urandom_range(0, 4)) : extra_lat;
                repeat (d + 1) @(posedge clk);
                #1 mem_rvalid = 1'b1;
                mem_rdata  = pix(a);
                @(posedge clk);
                #1 mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT reads or completes.
    always @(negedge clk) begin
        exp_t e;
        logic [17:0] ea;
        if (rst) begin
            h00 = '0; h01 = '0; h10 = '0; h11 = '0; hfx = '0; hfy = '0;
        end else begin
            if (mem_rd) begin
                rd_count++;
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_mem_rd", {14'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    ea = exp_addr_q.pop_front();
                    chk("mem_addr", {14'd0, mem_addr}, {14'd0, ea});
                end
            end
            if (fetch_done) begin
                done_count++;
                if (exp_res_q.size() == 0) begin
                    chk("unexpected_fetch_done", 32'd1, 32'd0);
                end else begin
                    e = exp_res_q.pop_front();
                    chk("p00", {24'd0, p00}, {24'd0, e.p00});
                    chk("p01", {24'd0, p01}, {24'd0, e.p01});
                    chk("p10", {24'd0, p10}, {24'd0, e.p10});
                    chk("p11", {24'd0, p11}, {24'd0, e.p11});
                    chk("frac_x", {24'd0, frac_x}, {24'd0, e.fx});
                    chk("frac_y", {24'd0, frac_y}, {24'd0, e.fy});
                    if (e.lat >= 0) chk("latency", 32'(cyc - req_cyc), 32'(e.lat));
                end
                h00 = p00; h01 = p01; h10 = p10; h11 = p11; hfx = frac_x; hfy = frac_y;
            end else if (busy && chk_hold) begin
                chk("hold_outputs", {p00, p01, p10, p11}, {h00, h01, h10, h11});
                chk("hold_frac", {16'd0, frac_x, frac_y}, {16'd0, hfx, hfy});
            end
        end
    end

    task automatic request(input logic [15:0] x, y, w, h, sx, sy, input logic [17:0] base,
                           input logic [17:0] a0, a1, a2, a3,
                           input logic [7:0] fx, fy, input int lat);
        exp_t e;
        exp_addr_q.push_back(a0); exp_addr_q.push_back(a1);
        exp_addr_q.push_back(a2); exp_addr_q.push_back(a3);
        e.p00 = pix(a0); e.p01 = pix(a1); e.p10 = pix(a2); e.p11 = pix(a3);
        e.fx = fx; e.fy = fy; e.lat = lat;
        exp_res_q.push_back(e);
        @(negedge clk);
        dst_x = x; dst_y = y; img_width_in = w; img_height_in = h;
        scale_x = sx; scale_y = sy; base_addr = base;
        fetch_req = 1'b1;
        req_cyc = cyc;
        @(negedge clk);
        fetch_req = 1'b0;
    endtask

    task automatic wait_done(input int n0);
        for (int i = 0; i < 300 && done_count == n0; i++) @(negedge clk);
        chk("done_timeout", 32'(done_count != n0), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int rd0, d0;
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, d0;
        rst = 1'b1; fetch_req = 1'b0;
        dst_x = '0; dst_y = '0; img_width_in = '0; img_height_in = '0;
        scale_x = '0; scale_y = '0; base_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {p00, p01, p10, p11}, 32'd0);
        chk("rst_ctrl", {16'd0, frac_x, frac_y}, 32'd0);
        chk("rst_flags", {29'd0, mem_rd, fetch_done, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Upscale interior point
        d0 = done_count;
        request(16'd3, 16'd5, 16'd4, 16'd4, 16'h0080, 16'h0080, 18'h0,
                18'd9, 18'd10, 18'd13, 18'd14, 8'h80, 8'h80, 11);
        wait_done(d0);

        // Edge clamp: all neighbours collapse to (3,3)
        d0 = done_count;
        request(16'd7, 16'd7, 16'd4, 16'd4, 16'h0080, 16'h0080, 18'h0,
                18'd15, 18'd15, 18'd15, 18'd15, 8'h80, 8'h80, 11);
        wait_done(d0);

        // Out-of-range x clamps to W-1 with zero weight
        d0 = done_count;
        request(16'd5, 16'd0, 16'd4, 16'd4, 16'h0100, 16'h0100, 18'h0,
                18'd3, 18'd3, 18'd7, 18'd7, 8'h00, 8'h00, 11);
        wait_done(d0);

        // Identity scale with base offset
        d0 = done_count;
        request(16'd2, 16'd1, 16'd4, 16'd4, 16'h0100, 16'h0100, 18'h100,
                18'h106, 18'h107, 18'h10A, 18'h10B, 8'h00, 8'h00, 11);
        wait_done(d0);

        // Variable latency plus a request pulsed while busy
        rand_lat = 1'b1; chk_hold = 1'b1;
        rd0 = rd_count; d0 = done_count;
        request(16'd3, 16'd5, 16'd4, 16'd4, 16'h0080, 16'h0080, 18'h0,
                18'd9, 18'd10, 18'd13, 18'd14, 8'h80, 8'h80, -1);
        repeat (4) @(negedge clk);
        dst_x = 16'd7; dst_y = 16'd7; fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        wait_done(d0);
        repeat (30) @(negedge clk);
        chk("var_lat_reads", 32'(rd_count - rd0), 32'd4);
        chk("var_lat_dones", 32'(done_count - d0), 32'd1);
        chk("busy_after", {31'd0, busy}, 32'd0);
        rand_lat = 1'b0; chk_hold = 1'b0;

        // Reset while waiting on the second read
        extra_lat = 4;
        rd0 = rd_count; d0 = done_count;
        request(16'd2, 16'd1, 16'd4, 16'd4, 16'h0100, 16'h0100, 18'h100,
                18'h106, 18'h107, 18'h10A, 18'h10B, 8'h00, 8'h00, 11);
        for (int i = 0; i < 100 && rd_count < rd0 + 2; i++) @(negedge clk);
        chk("reads_before_rst", 32'(rd_count - rd0), 32'd2);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {p00, p01, p10, p11}, 32'd0);
        chk("midrst_frac", {16'd0, frac_x, frac_y}, 32'd0);
        chk("midrst_flags", {29'd0, mem_rd, fetch_done, busy}, 32'd0);
        exp_addr_q.delete();
        exp_res_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd0 = rd_count;
        repeat (15) @(negedge clk);
        chk("no_reads_after_rst", 32'(rd_count - rd0), 32'd0);
        chk("no_done_after_rst", 32'(done_count - d0), 32'd0);
        chk("idle_after_late_rvalid", {31'd0, busy}, 32'd0);
        extra_lat = 0;

        // Normal completion after the aborted fetch
        d0 = done_count;
        request(16'd3, 16'd5, 16'd4, 16'd4, 16'h0080, 16'h0080, 18'h0,
                18'd9, 18'd10, 18'd13, 18'd14, 8'h80, 8'h80, 11);
        wait_done(d0);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_addr_q.size() + exp_res_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
